word_serializer: RTL

Upstream feeder for the serial sequence detector. Accepts parallel words through a valid/ready handshake, buffers them in a small FIFO, and shifts each word out one bit per clock, MSB-first, on `x_out`, which drives the detector's `x_in`. Words are sent back-to-back with no idle cycles while the FIFO holds data, so the detector sees one continuous bit stream.

---
 rtl/word_serializer_if.sv | 26 ++
 rtl/word_serializer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/word_serializer_if.sv
// Parallel-in / serial-out handshake bundle for word_serializer.
// The master side feeds words and watches the serial stream; the slave is the serializer.
interface word_serializer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             ready;
    logic             x_out;
    logic             x_valid;
    logic             busy;
    logic [CW-1:0]    count;

    modport master (
        output data_in, load,
        input  ready, x_out, x_valid, busy, count
    );

    modport slave (
        input  data_in, load,
        output ready, x_out, x_valid, busy, count
    );
endinterface

// File: rtl/word_serializer.sv
// Buffers parallel words in a small FIFO and shifts them out MSB-first as one gapless bit stream.
// Optional trailing even-parity bit per frame when WORD_SERIALIZER_PARITY_EN is defined.
module word_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    word_serializer_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

`ifdef WORD_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BW-1:0]    bit_cnt_q;
    logic             x_out_q;
    logic             x_valid_q;
`ifdef WORD_SERIALIZER_PARITY_EN
    logic             parity_q;
`endif

    logic             push;
    logic             pop;
    logic             have_word;
    logic [WIDTH-1:0] head;

    assign have_word = (count_q != '0);
    assign push      = bus.load && bus.ready;
    assign head      = mem_q[rd_ptr_q];

    // A pop happens exactly when the FSM starts a new frame.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            IDLE:    pop = have_word;
`ifdef WORD_SERIALIZER_PARITY_EN
            SHIFT:   pop = 1'b0;
            PARITY:  pop = have_word;
`else
            SHIFT:   pop = (bit_cnt_q == LAST_BIT) && have_word;
`endif
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            x_out_q   <= 1'b0;
            x_valid_q <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (pop) begin
            state_q   <= SHIFT;
            shreg_q   <= head;
            bit_cnt_q <= '0;
            x_out_q   <= head[WIDTH-1];
            x_valid_q <= 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
            parity_q  <= ^head;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (bit_cnt_q != LAST_BIT) begin
                        shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        x_out_q   <= shreg_q[WIDTH-2];
                    end else begin
`ifdef WORD_SERIALIZER_PARITY_EN
                        state_q   <= PARITY;
                        x_out_q   <= parity_q;
`else
                        state_q   <= IDLE;
                        x_out_q   <= 1'b0;
                        x_valid_q <= 1'b0;
`endif
                    end
                end
`ifdef WORD_SERIALIZER_PARITY_EN
                PARITY: begin
                    state_q   <= IDLE;
                    x_out_q   <= 1'b0;
                    x_valid_q <= 1'b0;
                end
`endif
                default: begin
                    state_q   <= IDLE;
                    x_out_q   <= 1'b0;
                    x_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready   = (count_q < FULL);
    assign bus.busy    = (state_q != IDLE) || have_word;
    assign bus.count   = count_q;
    assign bus.x_out   = x_out_q;
    assign bus.x_valid = x_valid_q;

endmodule
